// File: rtl/shared_mem_pkg.sv
// Shared types and helpers for the banked shared memory: FSM states,
// address-to-bank/row slicing and the pass-counter width.
package shared_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVICE = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic int bank_of(input logic [31:0] addr, input int bank_bits);
    return int'(addr & ((32'd1 << bank_bits) - 32'd1));
  endfunction

  function automatic int row_of(input logic [31:0] addr, input int bank_bits);
    return int'(addr >> bank_bits);
  endfunction

  // Passes range 0..lanes, so one extra bit beyond the lane index width.
  function automatic int pass_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/shared_mem_bank.sv
// Single scratchpad bank: synchronous RAM with write enable and a
// registered (1-cycle) read port; contents are never reset.
module shared_mem_bank #(
  parameter int ROW_W      = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ROW_W-1:0]      i_row,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ROW_W];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_row] <= i_wdata;
    r_rdata <= r_mem[i_row];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/shared_memory_banked.sv
// Warp-wide banked shared memory with bank-conflict serialization.
// Define SHARED_MEM_BROADCAST_EN to merge same-address load lanes into one grant.
module shared_memory_banked
  import shared_mem_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int NUM_BANKS     = 4,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [NUM_LANES-1:0]              req_mask,
  input  logic [NUM_LANES*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   req_wdata,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   resp_rdata,
  output logic [pass_width(NUM_LANES)-1:0]  resp_passes
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_W     = ADDRESS_WIDTH - BANK_BITS;
  localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PW        = pass_width(NUM_LANES);

  state_t                             r_state, w_state_next;
  logic                               r_write;
  logic [NUM_LANES-1:0]               r_pending, r_grant_q, w_grant;
  logic [NUM_LANES*ADDRESS_WIDTH-1:0] r_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0]    r_wdata, r_rdata;
  logic [PW-1:0]                      r_passes;

  logic [ADDRESS_WIDTH-1:0] w_lane_addr  [NUM_LANES];
  logic [BANK_BITS-1:0]     w_lane_bank  [NUM_LANES];
  logic [ROW_W-1:0]         w_lane_row   [NUM_LANES];
  logic [DATA_WIDTH-1:0]    w_lane_wdata [NUM_LANES];

  logic                     w_sel_valid  [NUM_BANKS];
  logic [LW-1:0]            w_sel_lane   [NUM_BANKS];
  logic                     w_bank_we    [NUM_BANKS];
  logic [ROW_W-1:0]         w_bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0]    w_bank_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0]    w_bank_rdata [NUM_BANKS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_lane_addr[gi]  = r_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign w_lane_bank[gi]  = BANK_BITS'(bank_of(32'(w_lane_addr[gi]), BANK_BITS));
      assign w_lane_row[gi]   = ROW_W'(row_of(32'(w_lane_addr[gi]), BANK_BITS));
      assign w_lane_wdata[gi] = r_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Each bank picks its lowest-indexed pending lane (descending scan, last hit wins).
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_sel_valid[b] = 1'b0;
      w_sel_lane[b]  = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (r_pending[i] && (w_lane_bank[i] == BANK_BITS'(b))) begin
          w_sel_valid[b] = 1'b1;
          w_sel_lane[b]  = LW'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic w_match;
`ifdef SHARED_MEM_BROADCAST_EN
      w_match = !r_write &&
                (w_lane_addr[i] == w_lane_addr[w_sel_lane[w_lane_bank[i]]]);
`else
      w_match = 1'b0;
`endif
      w_grant[i] = (r_state == ST_SERVICE) && r_pending[i] &&
                   w_sel_valid[w_lane_bank[i]] &&
                   ((w_sel_lane[w_lane_bank[i]] == LW'(i)) || w_match);
    end
  end

  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign w_bank_we[gi]    = (r_state == ST_SERVICE) && r_write && w_sel_valid[gi];
      assign w_bank_row[gi]   = w_lane_row[w_sel_lane[gi]];
      assign w_bank_wdata[gi] = w_lane_wdata[w_sel_lane[gi]];

      shared_mem_bank #(
        .ROW_W      (ROW_W),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .clk     (clk),
        .i_we    (w_bank_we[gi]),
        .i_row   (w_bank_row[gi]),
        .i_wdata (w_bank_wdata[gi]),
        .o_rdata (w_bank_rdata[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (req_valid) w_state_next = ST_SERVICE;
      ST_SERVICE: if (r_pending == '0) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_RESP;
      ST_RESP:    if (resp_ready) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_pending <= '0;
      r_grant_q <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_passes  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant_q <= r_write ? '0 : w_grant;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_write   <= req_write;
          r_pending <= req_mask;
          r_addr    <= req_addr;
          r_wdata   <= req_wdata;
          r_rdata   <= '0;
          r_passes  <= '0;
        end
        ST_SERVICE: begin
          r_pending <= r_pending & ~w_grant;
          if (w_grant != '0) r_passes <= r_passes + PW'(1);
        end
        default: ;
      endcase
      // Bank read data lands one cycle after the grant that requested it.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (r_grant_q[i]) r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= w_bank_rdata[w_lane_bank[i]];
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_rdata  = r_rdata;
  assign resp_passes = r_passes;

endmodule
